// File: rtl/clk_divider_multi_if.sv
// clk_divider_multi_if: per-channel enable/divisor inputs and divided clock/tick outputs.
// Burst strobes and status exist only when CLK_DIVIDER_BURST_EN is defined.
interface clk_divider_multi_if #(
    parameter int SIZE     = 16,
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0]      en_in;
    logic [CHANNELS*SIZE-1:0] max_in;
    logic [CHANNELS-1:0]      clk_out;
    logic [CHANNELS-1:0]      tick_out;
`ifdef CLK_DIVIDER_BURST_EN
    logic [CHANNELS-1:0]      start_in;
    logic [CHANNELS*SIZE-1:0] steps_in;
    logic [CHANNELS-1:0]      busy_out;
    modport master (output en_in, max_in, start_in, steps_in, input clk_out, tick_out, busy_out);
    modport slave  (input en_in, max_in, start_in, steps_in, output clk_out, tick_out, busy_out);
`else
    modport master (output en_in, max_in, input clk_out, tick_out);
    modport slave  (input en_in, max_in, output clk_out, tick_out);
`endif
endinterface

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: independent per-channel toggle dividers with shadowed divisor and tick.
// Define CLK_DIVIDER_BURST_EN to add burst mode (exactly N full periods per start strobe).
module clk_divider_multi #(
    parameter int SIZE     = 16,
    parameter int CHANNELS = 2
) (
    input logic                clk_in,
    input logic                rst_in,
    clk_divider_multi_if.slave bus
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SIZE-1:0] r_count, r_max, max_c;
        logic            r_clk, r_tick, run, term;
        assign max_c = bus.max_in[c*SIZE +: SIZE];
        // r_max-1 is only used when r_max is nonzero, so it never wraps
        assign term  = (r_max != '0) && (r_count >= r_max - 1'b1);
        assign bus.clk_out[c]  = r_clk;
        assign bus.tick_out[c] = r_tick;
`ifdef CLK_DIVIDER_BURST_EN
        logic [SIZE-1:0] r_steps, steps_c;
        logic            r_busy, start_ok;
        assign steps_c  = bus.steps_in[c*SIZE +: SIZE];
        assign start_ok = bus.start_in[c] && !r_busy && (steps_c != '0);
        assign run      = bus.en_in[c] || r_busy;
        assign bus.busy_out[c] = r_busy;
`else
        assign run = bus.en_in[c];
`endif
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                r_count <= '0;
                r_max   <= '0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
`ifdef CLK_DIVIDER_BURST_EN
                r_steps <= '0;
                r_busy  <= 1'b0;
`endif
            end
`ifdef CLK_DIVIDER_BURST_EN
            // a burst starts from a fresh low phase so it spans exactly N full periods
            else if (start_ok) begin
                r_count <= '0;
                r_max   <= max_c;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
                r_steps <= steps_c;
                r_busy  <= 1'b1;
            end
`endif
            else if (!run) begin
                r_count <= '0;
                r_max   <= max_c;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
            end
            else if (r_max == '0) begin
                r_max  <= max_c;
                r_tick <= 1'b0;
            end
            else if (term) begin
                r_count <= '0;
                r_max   <= max_c;
                r_clk   <= ~r_clk;
                r_tick  <= 1'b1;
`ifdef CLK_DIVIDER_BURST_EN
                if (r_busy && !r_clk)
                    r_steps <= r_steps - 1'b1;
                if (r_busy && r_clk && (r_steps == '0))
                    r_busy <= 1'b0;
`endif
            end
            else begin
                r_count <= r_count + 1'b1;
                r_tick  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clk_divider_multi.sv
// tb_clk_divider_multi: vector table, directed corner sequences and randomized run
// against a countdown reference model of the divider.
module tb_clk_divider_multi;
    localparam int SIZE = 8;
    localparam int CH   = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    clk_divider_multi_if #(.SIZE(SIZE), .CHANNELS(CH)) bus ();
    clk_divider_multi #(.SIZE(SIZE), .CHANNELS(CH)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    // reference: divisor in use and edges left until the next toggle
    int div [CH];
    int left[CH];
    logic [CH-1:0] m_clk, m_tick;

    typedef struct {
        logic [1:0] en;
        logic [7:0] m0, m1;
        logic [1:0] clk, tick;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        for (int c = 0; c < CH; c++) begin
            int m;
            m = int'(bus.max_in[c*SIZE +: SIZE]);
            if (rst_in) begin
                div[c] = 0; left[c] = 0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
            end else if (!bus.en_in[c]) begin
                div[c] = m; left[c] = m; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
            end else if (div[c] == 0) begin
                div[c] = m; left[c] = m; m_tick[c] = 1'b0;
            end else begin
                left[c]--;
                m_tick[c] = (left[c] == 0);
                if (left[c] == 0) begin
                    m_clk[c] = ~m_clk[c];
                    div[c] = m;
                    left[c] = m;
                end
            end
        end
        #1;
    endtask

    task automatic wait_toggle(input int c, input int lim, output int n);
        logic v;
        v = bus.clk_out[c];
        n = 0;
        do begin
            step();
            n++;
        end while (bus.clk_out[c] === v && n < lim);
    endtask

    initial begin
        int n, highs, ticks, rises, busy_n;
        logic v;
        vt[0] = '{2'b00, 8'd3, 8'd1, 2'b00, 2'b00};
        vt[1] = '{2'b11, 8'd3, 8'd1, 2'b10, 2'b10};
        vt[2] = '{2'b11, 8'd3, 8'd1, 2'b00, 2'b10};
        vt[3] = '{2'b11, 8'd3, 8'd1, 2'b11, 2'b11};
        vt[4] = '{2'b11, 8'd3, 8'd1, 2'b01, 2'b10};
        vt[5] = '{2'b01, 8'd3, 8'd1, 2'b01, 2'b00};
        vt[6] = '{2'b01, 8'd3, 8'd1, 2'b00, 2'b01};
        vt[7] = '{2'b00, 8'd3, 8'd1, 2'b00, 2'b00};
        rst_in = 1'b1;
        bus.en_in = '0;
        bus.max_in = '0;
`ifdef CLK_DIVIDER_BURST_EN
        bus.start_in = '0;
        bus.steps_in = '0;
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_clk", bus.clk_out, 0);
            chk("reset_tick", bus.tick_out, 0);
        end
        rst_in = 1'b0;
        step();
        chk("post_reset_clk", bus.clk_out, 0);
        chk("post_reset_tick", bus.tick_out, 0);

        for (int i = 0; i < 8; i++) begin
            bus.en_in = vt[i].en;
            bus.max_in = {vt[i].m1, vt[i].m0};
            step();
            chk($sformatf("vec%0d_clk", i), bus.clk_out, vt[i].clk);
            chk($sformatf("vec%0d_tick", i), bus.tick_out, vt[i].tick);
        end

        // max=5: first rise after 5 edges, then 5 high / 5 low, tick every 5
        bus.max_in = {8'd0, 8'd5};
        step();
        bus.en_in = 2'b01;
        wait_toggle(0, 20, n);
        chk("m5_first_rise", n, 5);
        chk("m5_rise_tick", bus.tick_out[0], 1);
        wait_toggle(0, 20, n);
        chk("m5_high_len", n, 5);
        wait_toggle(0, 20, n);
        chk("m5_low_len", n, 5);
        highs = 0; ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            highs += int'(bus.clk_out[0]);
            ticks += int'(bus.tick_out[0]);
        end
        chk("m5_duty", highs, 10);
        chk("m5_ticks", ticks, 4);

        // divisor change mid half-period waits for the next toggle
        bus.en_in = 2'b00;
        bus.max_in = {8'd0, 8'd4};
        step();
        bus.en_in = 2'b01;
        wait_toggle(0, 20, n);
        chk("m4_first_rise", n, 4);
        step();
        step();
        bus.max_in = {8'd0, 8'd2};
        wait_toggle(0, 20, n);
        chk("no_runt_half", n + 2, 4);
        wait_toggle(0, 20, n);
        chk("new_half_a", n, 2);
        wait_toggle(0, 20, n);
        chk("new_half_b", n, 2);

        // max=1 toggles every edge, then max=0 freezes
        bus.en_in = 2'b00;
        bus.max_in = {8'd0, 8'd1};
        step();
        bus.en_in = 2'b01;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("m1_clk", bus.clk_out[0], (i % 2) == 0);
            chk("m1_tick", bus.tick_out[0], 1);
        end
        bus.max_in = {8'd0, 8'd0};
        step();
        chk("m0_last_tick", bus.tick_out[0], 1);
        v = bus.clk_out[0];
        for (int i = 0; i < 5; i++) begin
            step();
            chk("m0_frozen_clk", bus.clk_out[0], v);
            chk("m0_tick_low", bus.tick_out[0], 0);
        end
        bus.max_in = {8'd0, 8'd3};
        wait_toggle(0, 20, n);
        chk("m0_restart", n, 4);

        // enable drop mid-period restarts a fresh period
        wait_toggle(0, 20, n);
        chk("m3_rise", n, 3);
        step();
        bus.en_in = 2'b00;
        step();
        chk("en_drop_clk", bus.clk_out[0], 0);
        chk("en_drop_tick", bus.tick_out[0], 0);
        bus.en_in = 2'b01;
        wait_toggle(0, 20, n);
        chk("en_restart", n, 3);
        chk("en_restart_level", bus.clk_out[0], 1);

        // largest half-period on channel 1
        bus.en_in = 2'b00;
        bus.max_in = {8'd255, 8'd0};
        step();
        bus.en_in = 2'b10;
        wait_toggle(1, 300, n);
        chk("max_half_period", n, 255);

        // randomized run against the model, with a shared reset to align state
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) bus.en_in[c] = 1'($urandom);
                if ($urandom_range(0, 9) == 0) bus.max_in[c*SIZE +: SIZE] = 8'($urandom_range(0, 6));
            end
            step();
            chk("rand_clk", bus.clk_out, m_clk);
            chk("rand_tick", bus.tick_out, m_tick);
        end

`ifdef CLK_DIVIDER_BURST_EN
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        bus.en_in = 2'b00;
        bus.max_in = {8'd0, 8'd2};
        bus.steps_in = {8'd0, 8'd0};
        bus.start_in = 2'b01;
        step();
        chk("burst_zero_noop", bus.busy_out[0], 0);
        bus.steps_in = {8'd0, 8'd3};
        step();
        bus.start_in = 2'b00;
        chk("burst_busy_set", bus.busy_out[0], 1);
        busy_n = 1; rises = 0;
        for (int i = 0; i < 100 && bus.busy_out[0]; i++) begin
            v = bus.clk_out[0];
            if (i == 3) begin
                bus.steps_in = {8'd0, 8'd5};
                bus.start_in = 2'b01;
            end else
                bus.start_in = 2'b00;
            step();
            rises += int'(!v && bus.clk_out[0]);
            busy_n += int'(bus.busy_out[0]);
        end
        chk("burst_busy_len", busy_n, 12);
        chk("burst_rises", rises, 3);
        chk("burst_end_low", bus.clk_out[0], 0);
        step();
        chk("burst_stays_idle", bus.busy_out[0], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
